crdhold_arb: RTL and testbench

CRDHOLD_ARB -- requirements
Module: crdhold_arb

---
 rtl/crdhold_arb.sv | 224 ++++++++++++++++++++++
 tb/tb_crdhold_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crdhold_arb.sv
// crdhold_arb -- two-requester arbiter in front of a shared crdhold unit.
//
// Each requester owns two token streams (K = 0, 1). Once a requester is
// granted, both of its streams are forwarded combinationally to the shared
// outputs crd_out_K, and crd_out_K_ready is returned to it. The grant is held
// until a DONE_TOKEN has been transferred on both streams. After a stream's
// DONE it is blocked so trailing tokens are never forwarded. Contention is
// resolved round-robin, and requester 0 wins first after reset.
//
// Parameters
//   DATA_WIDTH   token width (bit 16 is the control flag)
//   DONE_TOKEN   end-of-stream token value
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   clk_en              global enable; 0 holds all state
//   flush               synchronous soft clear (same effect as reset)
//   tile_en             0 forces all readies/valids low and holds state
//   rN_crd_in_K*        requester N stream K: data/valid in, ready out
//   crd_out_K*          shared stream K: data/valid out, ready in
//   grant               one-hot owner (01 = r0, 10 = r1, 00 = none)
//   xfer_count          tokens forwarded in the current grant, including
//                       the current cycle's transfers; saturates at 16'hFFFF
//
// Optional feature (macro CRDHOLD_ARB_PERF_EN)
//   busy_cycles         32-bit wrapping count of cycles with a grant active
//                       and clk_en = 1; cleared by reset or flush

module crdhold_arb #(
    parameter int unsigned           DATA_WIDTH = 17,
    parameter logic [DATA_WIDTH-1:0] DONE_TOKEN = 17'h10100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  tile_en,

    input  logic [DATA_WIDTH-1:0] r0_crd_in_0,
    input  logic                  r0_crd_in_0_valid,
    output logic                  r0_crd_in_0_ready,
    input  logic [DATA_WIDTH-1:0] r0_crd_in_1,
    input  logic                  r0_crd_in_1_valid,
    output logic                  r0_crd_in_1_ready,

    input  logic [DATA_WIDTH-1:0] r1_crd_in_0,
    input  logic                  r1_crd_in_0_valid,
    output logic                  r1_crd_in_0_ready,
    input  logic [DATA_WIDTH-1:0] r1_crd_in_1,
    input  logic                  r1_crd_in_1_valid,
    output logic                  r1_crd_in_1_ready,

    output logic [DATA_WIDTH-1:0] crd_out_0,
    output logic                  crd_out_0_valid,
    input  logic                  crd_out_0_ready,
    output logic [DATA_WIDTH-1:0] crd_out_1,
    output logic                  crd_out_1_valid,
    input  logic                  crd_out_1_ready,

`ifdef CRDHOLD_ARB_PERF_EN
    output logic [31:0]           busy_cycles,
`endif

    output logic [1:0]            grant,
    output logic [15:0]           xfer_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StGrant0 = 2'b01,
        StGrant1 = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic        last_q, last_d;     // requester granted most recently
    logic [1:0]  done_q, done_d;     // per-stream DONE seen in this grant
    logic [15:0] count_q, count_d;   // transfers completed in earlier cycles

    // Requester-indexed views of the input ports.
    logic [DATA_WIDTH-1:0] in_data  [2][2];
    logic [1:0]            in_valid [2];
    logic [1:0]            in_ready [2];

    assign in_data[0][0] = r0_crd_in_0;
    assign in_data[0][1] = r0_crd_in_1;
    assign in_data[1][0] = r1_crd_in_0;
    assign in_data[1][1] = r1_crd_in_1;

    assign in_valid[0] = {r0_crd_in_1_valid, r0_crd_in_0_valid};
    assign in_valid[1] = {r1_crd_in_1_valid, r1_crd_in_0_valid};

    assign r0_crd_in_0_ready = in_ready[0][0];
    assign r0_crd_in_1_ready = in_ready[0][1];
    assign r1_crd_in_0_ready = in_ready[1][0];
    assign r1_crd_in_1_ready = in_ready[1][1];

    logic [1:0]            out_ready;
    logic [1:0]            out_valid;
    logic [DATA_WIDTH-1:0] out_data [2];

    assign out_ready = {crd_out_1_ready, crd_out_0_ready};

    assign crd_out_0       = out_data[0];
    assign crd_out_1       = out_data[1];
    assign crd_out_0_valid = out_valid[0];
    assign crd_out_1_valid = out_valid[1];

    logic        active;     // forwarding and state updates permitted
    logic        granted;
    logic        owner;
    logic [1:0]  fire;
    logic [1:0]  done_hit;
    logic [1:0]  done_now;
    logic        done_all;
    logic [1:0]  nfire;
    logic [16:0] count_sum;
    logic [15:0] count_inc;
    logic        req0, req1;

    // Forwarding datapath. Handshakes are also suppressed while clk_en = 0:
    // state cannot advance then, so a visible transfer would be lost.
    always_comb begin
        active  = clk_en & tile_en;
        granted = (state_q != StIdle);
        owner   = (state_q == StGrant1);

        in_ready[0] = 2'b00;
        in_ready[1] = 2'b00;
        out_valid   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            out_data[k] = granted ? in_data[owner][k] : '0;
            if (active && granted && !done_q[k]) begin
                out_valid[k]       = in_valid[owner][k];
                in_ready[owner][k] = out_ready[k];
            end
        end

        fire = out_valid & out_ready;
        for (int k = 0; k < 2; k++) begin
            done_hit[k] = fire[k] & (out_data[k] == DONE_TOKEN);
        end
        done_now = done_q | done_hit;
        done_all = &done_now;

        nfire     = {1'b0, fire[0]} + {1'b0, fire[1]};
        count_sum = {1'b0, count_q} + {15'b0, nfire};
        count_inc = count_sum[16] ? 16'hFFFF : count_sum[15:0];

        grant      = state_q;
        xfer_count = granted ? count_inc : 16'h0000;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        done_d  = done_q;
        count_d = count_q;
        req0    = |in_valid[0];
        req1    = |in_valid[1];

        if (active) begin
            unique case (state_q)
                StIdle: begin
                    done_d  = 2'b00;
                    count_d = 16'h0000;
                    if (req0 && req1) begin
                        // Round-robin: prefer the requester not granted last.
                        state_d = last_q ? StGrant0 : StGrant1;
                    end else if (req0) begin
                        state_d = StGrant0;
                    end else if (req1) begin
                        state_d = StGrant1;
                    end
                end
                StGrant0, StGrant1: begin
                    if (done_all) begin
                        state_d = StIdle;
                        last_d  = owner;
                        done_d  = 2'b00;
                        count_d = 16'h0000;
                    end else begin
                        done_d  = done_now;
                        count_d = count_inc;
                    end
                end
                default: begin
                    state_d = StIdle;
                    done_d  = 2'b00;
                    count_d = 16'h0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            done_q  <= 2'b00;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

`ifdef CRDHOLD_ARB_PERF_EN
    logic [31:0] busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            busy_q <= 32'h0;
        end else if (clk_en && (state_q != StIdle)) begin
            busy_q <= busy_q + 32'h1;
        end
    end

    assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_crdhold_arb.sv
module tb_crdhold_arb;

    localparam logic [16:0] DONE = 17'h10100;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, flush, tile_en;
    logic [16:0] din [2][2];
    logic        vin [2][2];
    logic        ordy [2];
    logic        r0_rdy0, r0_rdy1, r1_rdy0, r1_rdy1;
    logic [16:0] out0, out1;
    logic        out0_v, out1_v;
    logic [1:0]  grant;
    logic [15:0] xfer_count;
`ifdef CRDHOLD_ARB_PERF_EN
    logic [31:0] busy_cycles;
`endif

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    crdhold_arb dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_en            (clk_en),
        .flush             (flush),
        .tile_en           (tile_en),
        .r0_crd_in_0       (din[0][0]),
        .r0_crd_in_0_valid (vin[0][0]),
        .r0_crd_in_0_ready (r0_rdy0),
        .r0_crd_in_1       (din[0][1]),
        .r0_crd_in_1_valid (vin[0][1]),
        .r0_crd_in_1_ready (r0_rdy1),
        .r1_crd_in_0       (din[1][0]),
        .r1_crd_in_0_valid (vin[1][0]),
        .r1_crd_in_0_ready (r1_rdy0),
        .r1_crd_in_1       (din[1][1]),
        .r1_crd_in_1_valid (vin[1][1]),
        .r1_crd_in_1_ready (r1_rdy1),
        .crd_out_0         (out0),
        .crd_out_0_valid   (out0_v),
        .crd_out_0_ready   (ordy[0]),
        .crd_out_1         (out1),
        .crd_out_1_valid   (out1_v),
        .crd_out_1_ready   (ordy[1]),
`ifdef CRDHOLD_ARB_PERF_EN
        .busy_cycles       (busy_cycles),
`endif
        .grant             (grant),
        .xfer_count        (xfer_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the owner (-1 = none), who went last, which streams
    // have finished, and how many tokens moved so far in this grant.
    int          m_owner = -1;
    int          m_last  = 1;
    bit          m_done [2] = '{0, 0};
    int          m_cnt   = 0;
    logic [31:0] m_busy  = 0;

    int  e_own, e_nf, e_cnt;
    bit  e_act, e_v [2], e_r [2][2], e_hit [2], e_r0, e_r1;

    always @(negedge clk) begin
        if (chk_en) begin
            e_own = m_owner;
            e_act = clk_en && tile_en;
            e_nf  = 0;
            for (int k = 0; k < 2; k++) begin
                e_v[k] = e_act && (e_own >= 0) && vin[(e_own < 0) ? 0 : e_own][k] && !m_done[k];
                for (int n = 0; n < 2; n++)
                    e_r[n][k] = e_act && (e_own == n) && ordy[k] && !m_done[k];
                if (e_v[k] && ordy[k]) e_nf++;
            end
            e_cnt = (m_cnt + e_nf > 65535) ? 65535 : m_cnt + e_nf;

            check("grant", {30'b0, grant},
                  (e_own < 0) ? 32'd0 : ((e_own == 0) ? 32'd1 : 32'd2));
            check("xfer_count", {16'b0, xfer_count}, (e_own < 0) ? 32'd0 : e_cnt);
            check("out0_valid", {31'b0, out0_v}, {31'b0, e_v[0]});
            check("out1_valid", {31'b0, out1_v}, {31'b0, e_v[1]});
            if (e_v[0]) check("out0_data", {15'b0, out0}, {15'b0, din[e_own][0]});
            if (e_v[1]) check("out1_data", {15'b0, out1}, {15'b0, din[e_own][1]});
            check("r0_ready0", {31'b0, r0_rdy0}, {31'b0, e_r[0][0]});
            check("r0_ready1", {31'b0, r0_rdy1}, {31'b0, e_r[0][1]});
            check("r1_ready0", {31'b0, r1_rdy0}, {31'b0, e_r[1][0]});
            check("r1_ready1", {31'b0, r1_rdy1}, {31'b0, e_r[1][1]});
`ifdef CRDHOLD_ARB_PERF_EN
            check("busy_cycles", busy_cycles, m_busy);
`endif

            // Advance the model to what the next edge must produce.
            if (!rst_n || flush) begin
                m_owner = -1; m_last = 1; m_done = '{0, 0}; m_cnt = 0; m_busy = 0;
            end else begin
                if (clk_en && e_own >= 0) m_busy = m_busy + 1;
                if (e_act) begin
                    if (e_own < 0) begin
                        e_r0 = vin[0][0] || vin[0][1];
                        e_r1 = vin[1][0] || vin[1][1];
                        if (e_r0 && e_r1) m_owner = (m_last == 1) ? 0 : 1;
                        else if (e_r0)    m_owner = 0;
                        else if (e_r1)    m_owner = 1;
                        m_cnt = 0;
                    end else begin
                        for (int k = 0; k < 2; k++)
                            e_hit[k] = e_v[k] && ordy[k] && (din[e_own][k] == DONE);
                        if ((m_done[0] || e_hit[0]) && (m_done[1] || e_hit[1])) begin
                            m_owner = -1; m_last = e_own; m_done = '{0, 0}; m_cnt = 0;
                        end else begin
                            m_done[0] = m_done[0] || e_hit[0];
                            m_done[1] = m_done[1] || e_hit[1];
                            m_cnt     = e_cnt;
                        end
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        #3;
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < 2; k++) begin
                vin[n][k] = 1'b0;
                din[n][k] = 17'h0;
            end
        ordy[0] = 1'b1; ordy[1] = 1'b1;
        flush = 1'b0; tile_en = 1'b1; clk_en = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic set_r(input int n, input logic v0, input logic [16:0] d0,
                         input logic v1, input logic [16:0] d1);
        vin[n][0] = v0; din[n][0] = d0;
        vin[n][1] = v1; din[n][1] = d1;
    endtask

    logic [16:0] q0 [$];
    logic [16:0] q1 [$];
    logic [16:0] got0 [$];
    logic [16:0] exp0 [4];
    bit          started, s0done, finished;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        chk_en = 1;
        cyc();
        rst_n = 1'b1;

        // Reset state.
        peek();
        check("reset_grant", {30'b0, grant}, 32'd0);
        check("reset_xfer", {16'b0, xfer_count}, 32'd0);
        check("reset_r0_ready0", {31'b0, r0_rdy0}, 32'd0);

        // Single grant: r0 sends 1,2,DONE on stream 0 and 5,DONE on stream 1.
        set_r(0, 1, 17'h1, 1, 17'h5);
        peek();
        check("single_idle_grant", {30'b0, grant}, 32'd0);
        check("single_idle_out0v", {31'b0, out0_v}, 32'd0);
        cyc();
        peek();
        check("single_grant01", {30'b0, grant}, 32'd1);
        check("single_tok0a", {15'b0, out0}, 32'h1);
        check("single_tok1a", {15'b0, out1}, 32'h5);
        cyc();
        set_r(0, 1, 17'h2, 1, DONE);
        peek();
        check("single_tok0b", {15'b0, out0}, 32'h2);
        check("single_xfer4", {16'b0, xfer_count}, 32'd4);
        cyc();
        set_r(0, 1, DONE, 1, 17'h9);
        peek();
        check("single_tok0c", {15'b0, out0}, {15'b0, DONE});
        check("single_post_done_blocked", {31'b0, out1_v}, 32'd0);
        check("single_xfer5", {16'b0, xfer_count}, 32'd5);
        cyc();
        set_r(0, 0, 17'h0, 0, 17'h0);
        peek();
        check("single_release", {30'b0, grant}, 32'd0);
        check("single_xfer_clear", {16'b0, xfer_count}, 32'd0);
        cyc();

        // Contention straight after reset: r0 first, then r1.
        do_reset();
        set_r(0, 1, 17'h21, 1, 17'h22);
        set_r(1, 1, 17'h31, 1, 17'h32);
        cyc();
        peek();
        check("cont_grant0_first", {30'b0, grant}, 32'd1);
        check("cont_r1_ready0", {31'b0, r1_rdy0}, 32'd0);
        check("cont_r1_ready1", {31'b0, r1_rdy1}, 32'd0);
        cyc();
        set_r(0, 1, DONE, 1, DONE);
        peek();
        check("cont_r1_blocked", {31'b0, r1_rdy0 | r1_rdy1}, 32'd0);
        cyc();
        set_r(0, 0, 17'h0, 0, 17'h0);
        peek();
        check("cont_idle_between", {30'b0, grant}, 32'd0);
        cyc();
        peek();
        check("cont_grant1_next", {30'b0, grant}, 32'd2);
        cyc();
        set_r(1, 1, DONE, 1, DONE);
        cyc();
        set_r(1, 0, 17'h0, 0, 17'h0);
        cyc();

        // Backpressure: crd_out_0_ready toggles; no loss or duplication.
        q0 = '{17'h11, 17'h22, 17'h33, DONE};
        q1 = '{DONE};
        got0.delete();
        exp0 = '{17'h11, 17'h22, 17'h33, DONE};
        started = 0; s0done = 0; finished = 0;
        for (int t = 0; t < 24 && !finished; t++) begin
            vin[0][0] = (q0.size() > 0);
            din[0][0] = (q0.size() > 0) ? q0[0] : 17'h0;
            vin[0][1] = (q1.size() > 0);
            din[0][1] = (q1.size() > 0) ? q1[0] : 17'h0;
            ordy[0]   = (t % 2 == 0);
            peek();
            if (grant == 2'b01) started = 1;
            if (started && grant == 2'b00) finished = 1;
            if (grant == 2'b01 && !s0done)
                check("bp_ready_mirror", {31'b0, r0_rdy0}, {31'b0, ordy[0]});
            if (out0_v && ordy[0]) got0.push_back(out0);
            if (vin[0][0] && r0_rdy0) begin
                if (q0[0] == DONE) s0done = 1;
                void'(q0.pop_front());
            end
            if (vin[0][1] && r0_rdy1) void'(q1.pop_front());
            cyc();
        end
        if (!finished) check("bp_timeout", 32'd0, 32'd1);
        check("bp_count", got0.size(), 32'd4);
        for (int i = 0; i < 4 && i < got0.size(); i++)
            check("bp_token", {15'b0, got0[i]}, {15'b0, exp0[i]});
        idle_inputs();
        cyc();

        // Non-DONE control token passes; post-DONE token is held off.
        set_r(0, 1, 17'h10000, 1, 17'h3);
        cyc();
        peek();
        check("stop_tok_pass", {15'b0, out0}, 32'h10000);
        check("stop_tok_valid", {31'b0, out0_v}, 32'd1);
        cyc();
        set_r(0, 1, DONE, 0, 17'h0);
        peek();
        check("stop_no_fsm_effect", {30'b0, grant}, 32'd1);
        cyc();
        set_r(0, 1, 17'h7, 0, 17'h0);
        peek();
        check("post_done_valid", {31'b0, out0_v}, 32'd0);
        check("post_done_ready", {31'b0, r0_rdy0}, 32'd0);
        cyc();
        set_r(0, 1, 17'h7, 1, DONE);
        peek();
        check("post_done_still", {31'b0, out0_v | r0_rdy0}, 32'd0);
        cyc();
        set_r(0, 0, 17'h0, 0, 17'h0);
        peek();
        check("stop_release", {30'b0, grant}, 32'd0);
        cyc();

        // Flush in the third cycle of GRANT1.
        set_r(1, 1, 17'h44, 1, 17'h55);
        cyc();
        cyc();
        cyc();
        peek();
        check("flush_pre_grant1", {30'b0, grant}, 32'd2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        set_r(0, 1, 17'h61, 1, 17'h62);
        peek();
        check("flush_grant", {30'b0, grant}, 32'd0);
        check("flush_xfer", {16'b0, xfer_count}, 32'd0);
        check("flush_valids", {30'b0, out1_v, out0_v}, 32'd0);
        cyc();
        peek();
        check("flush_then_r0", {30'b0, grant}, 32'd1);
        set_r(1, 0, 17'h0, 0, 17'h0);
        cyc();
        set_r(0, 1, DONE, 1, DONE);
        cyc();
        idle_inputs();
        cyc();

        // tile_en low mid-grant silences everything and holds the grant.
        set_r(0, 1, 17'h71, 1, 17'h72);
        cyc();
        tile_en = 1'b0;
        peek();
        check("tile_off_ready", {31'b0, r0_rdy0}, 32'd0);
        check("tile_off_valid", {31'b0, out0_v}, 32'd0);
        cyc();
        tile_en = 1'b1;
        peek();
        check("tile_hold_grant", {30'b0, grant}, 32'd1);
        set_r(0, 1, DONE, 1, DONE);
        cyc();
        idle_inputs();
        cyc();

`ifdef CRDHOLD_ARB_PERF_EN
        // A 10-cycle grant yields busy_cycles = 10, held in IDLE.
        do_reset();
        set_r(0, 1, 17'h81, 1, 17'h82);
        cyc();
        for (int i = 0; i < 9; i++) cyc();
        set_r(0, 1, DONE, 1, DONE);
        cyc();
        set_r(0, 0, 17'h0, 0, 17'h0);
        peek();
        check("perf_busy10", busy_cycles, 32'd10);
        cyc();
        peek();
        check("perf_busy_hold", busy_cycles, 32'd10);
        cyc();
`endif

        // Randomized traffic against the model.
        for (int t = 0; t < 4000; t++) begin
            for (int n = 0; n < 2; n++)
                for (int k = 0; k < 2; k++) begin
                    vin[n][k] = ($urandom_range(0, 1) == 1);
                    din[n][k] = ($urandom_range(0, 4) == 0) ? DONE
                              : (($urandom_range(0, 7) == 0) ? 17'h10000 | 17'($urandom_range(0, 255))
                                                             : 17'($urandom_range(0, 17'h1FFFF)));
                end
            ordy[0] = ($urandom_range(0, 3) != 0);
            ordy[1] = ($urandom_range(0, 3) != 0);
            tile_en = ($urandom_range(0, 9) != 0);
            clk_en  = ($urandom_range(0, 19) != 0);
            flush   = ($urandom_range(0, 79) == 0);
            rst_n   = ($urandom_range(0, 199) != 0);
            cyc();
        end

        idle_inputs();
        rst_n = 1'b1;
        cyc();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
